// File: rtl/matrix_pixel_fetch.sv
// matrix_pixel_fetch: reads the top- and bottom-half pixels for one column from a
// single-port framebuffer. Each pixel is reduced to one {R,G,B} bit-plane selected by
// brightness_mask.
// Optional build macro: MATRIX_PIXEL_FETCH_GAMMA_EN applies a square-law gamma
// correction to each channel before the mask is applied.
module matrix_pixel_fetch #(
    parameter int unsigned ROW_BITS  = 4,
    parameter int unsigned COL_BITS  = 6,
    parameter int unsigned CHAN_BITS = 6
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic                             pixel_req,
    input  logic [COL_BITS-1:0]              column_address,
    input  logic [ROW_BITS-1:0]              row_address,
    input  logic [CHAN_BITS-1:0]             brightness_mask,
    output logic [ROW_BITS+COL_BITS:0]       ram_addr,
    output logic                             ram_rd_en,
    input  logic [3*CHAN_BITS-1:0]           ram_rd_data,
    output logic [2:0]                       rgb_top,
    output logic [2:0]                       rgb_bottom,
    output logic                             pixel_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int unsigned SqBits = 2 * CHAN_BITS;

    typedef enum logic [1:0] {StIdle, StRdTop, StRdBot, StCapture} state_e;

    state_e                      state_q, state_d;
    logic [COL_BITS-1:0]         col_q;
    logic [ROW_BITS-1:0]         row_q;
    logic [CHAN_BITS-1:0]        mask_q;
    logic [ROW_BITS+COL_BITS:0]  ram_addr_q;
    logic [3*CHAN_BITS-1:0]      top_q;
    logic [2:0]                  rgb_top_q, rgb_bottom_q;
    logic [2:0]                  rgb_top_d, rgb_bottom_d;
    logic                        pixel_valid_q;
    logic                        overrun_q;

    // Per-channel transfer: gamma curve g = (c*c + 2^N - 1) >> N, or identity.
    function automatic logic [CHAN_BITS-1:0] chan_xform(input logic [CHAN_BITS-1:0] c);
`ifdef MATRIX_PIXEL_FETCH_GAMMA_EN
        logic [SqBits-1:0] sq;
        sq = SqBits'(c) * SqBits'(c) + SqBits'((1 << CHAN_BITS) - 1);
        return sq[SqBits-1:CHAN_BITS];
`else
        return c;
`endif
    endfunction

    // Reduce one {R,G,B} pixel to a single bit per channel under the plane mask.
    function automatic logic [2:0] bit_plane(input logic [3*CHAN_BITS-1:0] pix,
                                             input logic [CHAN_BITS-1:0]   mask);
        logic [2:0] bits;
        bits[2] = |(chan_xform(pix[3*CHAN_BITS-1:2*CHAN_BITS]) & mask);
        bits[1] = |(chan_xform(pix[2*CHAN_BITS-1:CHAN_BITS]) & mask);
        bits[0] = |(chan_xform(pix[CHAN_BITS-1:0]) & mask);
        return bits;
    endfunction

    // FSM state register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fixed four-cycle walk once a request is accepted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pixel_req) state_d = StRdTop;
            StRdTop:   state_d = StRdBot;
            StRdBot:   state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs: read strobe and busy follow the state; bit-planes built during CAPTURE
    always_comb begin
        ram_rd_en    = (state_q == StRdTop) || (state_q == StRdBot);
        busy         = (state_q != StIdle);
        // Bottom pixel arrives on ram_rd_data in CAPTURE and is consumed directly.
        rgb_top_d    = bit_plane(top_q, mask_q);
        rgb_bottom_d = bit_plane(ram_rd_data, mask_q);
    end

    // Datapath: request latch, address sequencing, pixel capture, sticky overrun
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            col_q         <= '0;
            row_q         <= '0;
            mask_q        <= '0;
            ram_addr_q    <= '0;
            top_q         <= '0;
            rgb_top_q     <= '0;
            rgb_bottom_q  <= '0;
            pixel_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            pixel_valid_q <= (state_q == StCapture);
            if (pixel_req && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (pixel_req) begin
                        col_q      <= column_address;
                        row_q      <= row_address;
                        mask_q     <= brightness_mask;
                        // Address moves together with the state so RD_TOP sees it at once.
                        ram_addr_q <= {1'b0, row_address, column_address};
                    end
                end
                StRdTop: begin
                    ram_addr_q <= {1'b1, row_q, col_q};
                end
                StRdBot: begin
                    top_q <= ram_rd_data;
                end
                StCapture: begin
                    rgb_top_q    <= rgb_top_d;
                    rgb_bottom_q <= rgb_bottom_d;
                end
                default: ;
            endcase
        end
    end

    assign ram_addr    = ram_addr_q;
    assign rgb_top     = rgb_top_q;
    assign rgb_bottom  = rgb_bottom_q;
    assign pixel_valid = pixel_valid_q;
    assign overrun     = overrun_q;

endmodule
